// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults and write-request payload for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned DWIDTH_DEF = 32;
    localparam int unsigned AWIDTH_DEF = 5;

    typedef struct packed {
        logic                  valid;
        logic [AWIDTH_DEF-1:0] addr;
        logic [DWIDTH_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_rr_pick.sv
// Two-input grant picker. RF_WB_RR_EN selects round-robin; otherwise fixed priority to input 0.
module rf_wb_rr_pick (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic same_addr,
    output logic grant0_c,
    output logic grant1_c
);

    logic contended;
    logic prefer1;

    assign contended = valid0 & valid1;

`ifdef RF_WB_RR_EN
    // Pointer only moves on a contended grant between distinct registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer1 <= 1'b0;
        end else if (contended && !same_addr) begin
            prefer1 <= ~prefer1;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;
    assign prefer1    = 1'b0;
`endif

    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (!rst) begin
            if (contended) begin
                // Same destination: requester 0 first so requester 1's value lands last.
                if (same_addr || !prefer1) begin
                    grant0_c = 1'b1;
                end else begin
                    grant1_c = 1'b1;
                end
            end else begin
                grant0_c = valid0;
                grant1_c = valid1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two requesters, one registered write port.
// Optional round-robin policy via macro RF_WB_RR_EN (default: fixed priority).
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned AWIDTH = AWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [AWIDTH-1:0]    req0_addr,
    input  logic [DWIDTH-1:0]    req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AWIDTH-1:0]    req1_addr,
    input  logic [DWIDTH-1:0]    req1_data,
    output logic                 req1_ready,
    output logic                 rf_we,
    output logic [AWIDTH-1:0]    rf_wa,
    output logic [DWIDTH-1:0]    rf_wd,
    output logic [2**AWIDTH-1:0] pending,
    output logic                 conflict
);

    localparam int unsigned NREG = 2 ** AWIDTH;

    logic              same_addr;
    logic              xfer;
    logic              sel_we;
    logic [AWIDTH-1:0] sel_wa;
    logic [DWIDTH-1:0] sel_wd;

    assign same_addr = (req0_addr == req1_addr);
    assign conflict  = !rst && req0_valid && req1_valid;

    rf_wb_rr_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .same_addr (same_addr),
        .grant0_c  (req0_ready),
        .grant1_c  (req1_ready)
    );

    // Mux the granted request; writes to x0 are accepted but never enabled.
    always_comb begin
        xfer   = 1'b0;
        sel_wa = req0_addr;
        sel_wd = req0_data;
        if (req0_valid && req0_ready) begin
            xfer = 1'b1;
        end else if (req1_valid && req1_ready) begin
            xfer   = 1'b1;
            sel_wa = req1_addr;
            sel_wd = req1_data;
        end
        sel_we = xfer && (sel_wa != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
            pending <= '0;
        end else begin
            rf_we   <= sel_we;
            pending <= sel_we ? (NREG'(1) << sel_wa) : '0;
            if (xfer) begin
                rf_wa <= sel_wa;
                rf_wd <= sel_wd;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table plus write scoreboard.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;
`ifdef RF_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, rf_we, conflict;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [NR-1:0] pending;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .pending    (pending),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    rst;
        wb_req_t q0;
        wb_req_t q1;
        logic    r0;
        logic    r1;
        logic    cf;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          known;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;
    logic          last_known = 1'b0;

    function automatic vec_t mk(logic rs, logic v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic v1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                logic r0, logic r1, logic cf);
        vec_t v;
        v.rst = rs;
        v.q0  = '{valid: v0, addr: a0, data: d0};
        v.q1  = '{valid: v1, addr: a1, data: d1};
        v.r0  = r0;
        v.r1  = r1;
        v.cf  = cf;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t accept(wb_req_t q);
        exp_t e;
        e.we    = (q.addr != '0);
        e.wa    = q.addr;
        e.wd    = q.data;
        e.known = (q.addr != '0);
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        exp_t got;
        logic [NR-1:0] exp_pend;

        // Transfers presented during reset must be dropped.
        vecs.push_back(mk(1, 1, 5'd5, 32'h0000DEAD, 1, 5'd6, 32'h1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 5'd5, 32'h0000DEAD, 1, 5'd6, 32'h1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(0, 1, 5'd3, 32'hAAAA0003, 1, 5'd7, 32'hBBBB0007,
                              !RR || (i % 2 == 0), RR && (i % 2 == 1), 1));
        end
        vecs.push_back(mk(0, 1, 5'd9, 32'h11110009, 1, 5'd9, 32'h22220009, 1, 0, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h22220009, 0, 1, 0));
        vecs.push_back(mk(0, 1, 5'd3, 32'hAAAA0013, 1, 5'd7, 32'hBBBB0017, 1, 0, 1));
        vecs.push_back(mk(0, 1, 5'd3, 32'hAAAA0023, 1, 5'd7, 32'hBBBB0027, !RR, RR, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h00001234, 0, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5'd31, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 1, 5'd1, 32'h0101_0000 + DW'(i), 1, 5'd2, 32'h0202_0000,
                              !RR || (i != 1), RR && (i == 1), 1));
        end
        // Reset while a write to register 4 sits in the output stage.
        vecs.push_back(mk(0, 1, 5'd4, 32'h00000044, 0, 5'd0, 32'h0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 5'd4, 32'h00000044, 1, 5'd8, 32'h00000088, 0, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd6, 32'h00000066, 0, 1, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'h0000A001, 1, 5'd2, 32'h0000B002, 1, 0, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0));

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst        = vecs[n].rst;
            req0_valid = vecs[n].q0.valid;
            req0_addr  = vecs[n].q0.addr;
            req0_data  = vecs[n].q0.data;
            req1_valid = vecs[n].q1.valid;
            req1_addr  = vecs[n].q1.addr;
            req1_data  = vecs[n].q1.data;
            #1;
            check($sformatf("row%0d req0_ready", n), 64'(req0_ready), 64'(vecs[n].r0));
            check($sformatf("row%0d req1_ready", n), 64'(req1_ready), 64'(vecs[n].r1));
            check($sformatf("row%0d conflict", n), 64'(conflict), 64'(vecs[n].cf));

            if (vecs[n].rst) begin
                e = '{we: 1'b0, wa: '0, wd: '0, known: 1'b1};
            end else if (vecs[n].r0 && vecs[n].q0.valid) begin
                e = accept(vecs[n].q0);
            end else if (vecs[n].r1 && vecs[n].q1.valid) begin
                e = accept(vecs[n].q1);
            end else begin
                e = '{we: 1'b0, wa: last_wa, wd: last_wd, known: last_known};
            end
            last_wa    = e.wa;
            last_wd    = e.wd;
            last_known = e.known;
            sb.push_back(e);

            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("row%0d scoreboard", n), 64'(0), 64'(1));
            end else begin
                got      = sb.pop_front();
                exp_pend = got.we ? (NR'(1) << got.wa) : '0;
                check($sformatf("row%0d rf_we", n), 64'(rf_we), 64'(got.we));
                check($sformatf("row%0d pending", n), 64'(pending), 64'(exp_pend));
                if (got.known) begin
                    check($sformatf("row%0d rf_wa", n), 64'(rf_wa), 64'(got.wa));
                    check($sformatf("row%0d rf_wd", n), 64'(rf_wd), 64'(got.wd));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
